// File: rtl/alu_seq.sv
// Registered N-bit ALU with logic, arithmetic, flags and illegal-op detection.
// Shifts and multiply run one bit per cycle under a start/busy/done handshake.
module alu_seq #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic [3:0]   i_operation,
  output logic [N-1:0] o_y,
  output logic [3:0]   o_flags,
  output logic         o_err,
  output logic         o_busy,
  output logic         o_done
);

  typedef enum logic [1:0] {
    S_IDLE, S_SHIFT, S_MUL, S_DONE
  } state_t;

  localparam logic [3:0] OP_SLL = 4'd3;
  localparam logic [3:0] OP_SRL = 4'd4;
  localparam logic [3:0] OP_SRA = 4'd5;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [N-1:0] CNT_N = N'(N);

  state_t r_state, w_next;

  logic [3:0]     r_op;
  logic [2*N-1:0] r_acc;
  logic [2*N-1:0] r_mc;
  logic [N-1:0]   r_b;
  logic [N-1:0]   r_cnt;
  logic           r_c, r_v, r_err;
  logic [N-1:0]   r_y;
  logic [3:0]     r_flags;
  logic           r_errout, r_done;

  logic [N:0]     w_sum;
  logic [N-1:0]   w_dif;
  logic [N-1:0]   w_cnt;
  logic [N-1:0]   w_res;
  logic           w_c, w_v;
  logic           w_is_shift;
  logic [N-1:0]   w_shn;
  logic           w_sho;
  logic [N-1:0]   w_yv;
  logic           w_fc, w_fv;
  logic           w_busy;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b};
  assign w_dif = i_a - i_b;
  assign w_cnt = (i_b > CNT_N) ? CNT_N : i_b;
  assign w_is_shift = (i_operation == OP_SLL) ||
                      (i_operation == OP_SRL) ||
                      (i_operation == OP_SRA);

  // Single-cycle result computed from live operands at accept
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (i_operation)
      4'd0: w_res = i_a & i_b;
      4'd1: w_res = i_a | i_b;
      4'd2: w_res = i_a ^ i_b;
      4'd3, 4'd4, 4'd5: w_res = i_a;
      4'd6: begin
        w_res = w_sum[N-1:0];
        w_c   = w_sum[N];
        w_v   = (i_a[N-1] == i_b[N-1]) &&
                (w_sum[N-1] != i_a[N-1]);
      end
      4'd7: begin
        w_res = w_dif;
        w_c   = (i_a >= i_b);
        w_v   = (i_a[N-1] != i_b[N-1]) &&
                (w_dif[N-1] != i_a[N-1]);
      end
      default: w_res = '0;
    endcase
  end

  // One-bit shift step on the working register
  always_comb begin
    w_shn = r_acc[N-1:0];
    w_sho = 1'b0;
    case (r_op)
      OP_SLL: begin
        w_shn = {r_acc[N-2:0], 1'b0};
        w_sho = r_acc[N-1];
      end
      OP_SRL: begin
        w_shn = {1'b0, r_acc[N-1:1]};
        w_sho = r_acc[0];
      end
      OP_SRA: begin
        w_shn = {r_acc[N-1], r_acc[N-1:1]};
        w_sho = r_acc[0];
      end
      default: w_sho = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_operation == OP_MUL)
            w_next = S_MUL;
          else if (w_is_shift && w_cnt != '0)
            w_next = S_SHIFT;
          else
            w_next = S_DONE;
        end
      end
      S_SHIFT: if (r_cnt == N'(1)) w_next = S_DONE;
      S_MUL:   if (r_cnt == N'(1)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
    endcase
  end

  // Outputs derived from state and working registers
  always_comb begin
    w_busy = (r_state != S_IDLE);
    w_yv   = r_acc[N-1:0];
    w_fc   = (r_op == OP_MUL) ? |r_acc[2*N-1:N] : r_c;
    w_fv   = (r_op == OP_MUL) ? |r_acc[2*N-1:N] : r_v;
  end

  // Working datapath: latch at accept, iterate in SHIFT/MUL
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op  <= '0;
      r_acc <= '0;
      r_mc  <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      r_c   <= 1'b0;
      r_v   <= 1'b0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_op  <= i_operation;
          r_acc <= {{N{1'b0}}, w_res};
          r_c   <= w_c;
          r_v   <= w_v;
          r_err <= (i_operation > OP_MUL);
          r_cnt <= (i_operation == OP_MUL) ? CNT_N : w_cnt;
          r_mc  <= {{N{1'b0}}, i_a};
          r_b   <= i_b;
        end
        S_SHIFT: begin
          r_acc[N-1:0] <= w_shn;
          r_c   <= w_sho;
          r_cnt <= r_cnt - N'(1);
        end
        S_MUL: begin
          if (r_b[0]) r_acc <= r_acc + r_mc;
          r_mc  <= r_mc << 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt - N'(1);
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Result, flags and done pulse published on leaving DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y      <= '0;
      r_flags  <= '0;
      r_errout <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      if (r_state == S_DONE) begin
        r_errout <= r_err;
        if (r_err) begin
          r_y     <= '0;
          r_flags <= '0;
        end else begin
          r_y     <= w_yv;
          r_flags <= {w_yv[N-1], (w_yv == '0), w_fc, w_fv};
        end
      end
    end
  end

  assign o_y     = r_y;
  assign o_flags = r_flags;
  assign o_err   = r_errout;
  assign o_busy  = w_busy;
  assign o_done  = r_done;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (N=4): results, flags, latency,
// busy-ignore of start and mid-operation reset.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a, b, op;
  logic [3:0] y, flags;
  logic       err, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  alu_seq #(.N(4)) dut (
    .clk(clk), .rst(rst), .i_start(start),
    .i_a(a), .i_b(b), .i_operation(op),
    .o_y(y), .o_flags(flags), .o_err(err),
    .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one request; returns just after the accept edge
  task automatic go(input logic [3:0] ia, ib, iop);
    @(negedge clk);
    a = ia; b = ib; op = iop; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~ia; b = ~ib; op = 4'd0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < 40);
  endtask

  task automatic run(input string tag,
                     input logic [3:0] ia, ib, iop,
                     input logic [3:0] ey, ef,
                     input logic ee, input int el);
    int lat;
    go(ia, ib, iop);
    if (el > 1) check({tag, ".busy"}, busy, 1);
    wait_done(lat);
    check({tag, ".lat"}, lat, el);
    check({tag, ".y"}, y, ey);
    check({tag, ".flags"}, flags, ef);
    check({tag, ".err"}, err, ee);
    check({tag, ".busydn"}, busy, 0);
  endtask

  initial begin
    int ndone, first;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; op = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.y", y, 0);
    check("rst.flags", flags, 0);
    check("rst.err", err, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    rst = 1'b0;

    //   tag     a      b      op    y      flags    err lat
    run("add",   4'h7,  4'h9,  4'd6, 4'h0,  4'b0110, 0,  1);
    run("sub1",  4'h3,  4'h5,  4'd7, 4'hE,  4'b1000, 0,  1);
    run("sub2",  4'h8,  4'h1,  4'd7, 4'h7,  4'b0011, 0,  1);
    run("mul1",  4'h5,  4'h3,  4'd8, 4'hF,  4'b1000, 0,  5);
    run("mul2",  4'h7,  4'h3,  4'd8, 4'h5,  4'b0011, 0,  5);
    run("sll",   4'hB,  4'h2,  4'd3, 4'hC,  4'b1000, 0,  3);
    run("sra",   4'h8,  4'h7,  4'd5, 4'hF,  4'b1010, 0,  5);
    run("srl1",  4'h9,  4'h1,  4'd4, 4'h4,  4'b0000 | 4'b0010, 0, 2);
    run("srl0",  4'h5,  4'h0,  4'd4, 4'h5,  4'b0000, 0,  1);
    run("ill",   4'h3,  4'h4,  4'hF, 4'h0,  4'b0000, 1,  1);
    run("and",   4'hC,  4'hA,  4'd0, 4'h8,  4'b1000, 0,  1);
    run("or",    4'h0,  4'h0,  4'd1, 4'h0,  4'b0100, 0,  1);
    run("xor",   4'h6,  4'h3,  4'd2, 4'h5,  4'b0000, 0,  1);

    // start pulsed while MUL busy is ignored
    go(4'h5, 4'h3, 4'd8);
    ndone = 0; first = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 2) begin
        a = 4'h1; b = 4'h1; op = 4'd6; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        ndone++;
        if (first == 0) first = k;
      end
    end
    check("ign.ndone", ndone, 1);
    check("ign.lat", first, 5);
    check("ign.y", y, 4'hF);

    // reset mid-MUL aborts without done
    go(4'h7, 4'h3, 4'd8);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort.busy", busy, 0);
    check("abort.done", done, 0);
    check("abort.y", y, 0);
    check("abort.flags", flags, 0);
    ndone = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort.nodone", ndone, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
